// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares the single Hack data-memory port between requester A (CPU data
//   port) and requester B (DMA / screen-scanout engine). At most one access
//   is granted per cycle, with round-robin ownership and a bounded burst
//   length per owner.
//
//   Optional feature macro: MEM_ARB_WRITE_PROTECT_EN
//     defined   : granted writes to address >= 15'h6000 (keyboard / unmapped)
//                 are dropped (mem_load held low), the grant is still issued
//                 and wr_err is set until reset.
//     undefined : all writes pass through unchanged, wr_err is tied low.
//
//   Handshake: a requester raises req_X together with we_X/addr_X/wdata_X and
//   holds all four stable until it sees gnt_X high in the same cycle; the
//   access commits at the rising edge that ends that cycle. gnt_X is a
//   combinational function of the requests and the registered arbiter state.
//   A read returns data one clock later: rvalid_X pulses for exactly one
//   cycle and rdata_X holds its value until the next read by X. Dropping
//   req_X before a grant simply abandons the access.
//
//   state_dbg / burst_cnt_dbg expose the arbiter FSM for observation.

module memory_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req_a,
  input  logic               we_a,
  input  logic [14:0]        addr_a,
  input  logic [15:0]        wdata_a,
  output logic               gnt_a,
  output logic               rvalid_a,
  output logic [15:0]        rdata_a,

  input  logic               req_b,
  input  logic               we_b,
  input  logic [14:0]        addr_b,
  input  logic [15:0]        wdata_b,
  output logic               gnt_b,
  output logic               rvalid_b,
  output logic [15:0]        rdata_b,

  output logic [15:0]        mem_in,
  output logic               mem_load,
  output logic [14:0]        mem_address,
  input  logic [15:0]        mem_out,

  output logic               wr_err,

  output logic [1:0]         state_dbg,
  output logic [CNT_W-1:0]   burst_cnt_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic [14:0]      PROT_BASE = 15'h6000;

  // last_owner encoding: 0 = A, 1 = B
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_owner;

  logic             burst_open;
  logic [CNT_W-1:0] burst_next;
  logic             any_gnt;
  logic             sel_we;
  logic [14:0]      sel_addr;
  logic [15:0]      sel_wdata;
  logic             wr_block;

  // The current owner may keep going while under its burst limit; once it
  // reaches the limit it only keeps the port if the other side is idle.
  assign burst_open = (burst_cnt < BURST_LIM);

  // Saturating increment used when the same owner is granted again.
  assign burst_next = (burst_cnt >= BURST_LIM) ? BURST_LIM : burst_cnt + CNT_W'(1);

  // Grant selection: combinational from requests and registered state.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req_a && req_b) begin
            if (last_owner == OWNER_B) gnt_a = 1'b1;
            else                       gnt_b = 1'b1;
          end else if (req_a) begin
            gnt_a = 1'b1;
          end else if (req_b) begin
            gnt_b = 1'b1;
          end
        end
        OWN_A: begin
          if (req_a && (burst_open || !req_b)) gnt_a = 1'b1;
          else if (req_b)                      gnt_b = 1'b1;
        end
        OWN_B: begin
          if (req_b && (burst_open || !req_a)) gnt_b = 1'b1;
          else if (req_a)                      gnt_a = 1'b1;
        end
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end
  end

  assign any_gnt = gnt_a | gnt_b;

  // Memory-port mux: drive the granted requester's command, zeros otherwise.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 15'd0;
    sel_wdata = 16'd0;
    if (gnt_a) begin
      sel_we    = we_a;
      sel_addr  = addr_a;
      sel_wdata = wdata_a;
    end else if (gnt_b) begin
      sel_we    = we_b;
      sel_addr  = addr_b;
      sel_wdata = wdata_b;
    end
  end

  assign mem_address = sel_addr;
  assign mem_in      = sel_wdata;
  assign mem_load    = any_gnt & sel_we & ~wr_block;

`ifdef MEM_ARB_WRITE_PROTECT_EN
  // Writes into the keyboard / unmapped region are suppressed at the port.
  assign wr_block = sel_we & (sel_addr >= PROT_BASE);

  // Sticky record that a protected write was dropped; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                wr_err <= 1'b0;
    else if (any_gnt && wr_block) wr_err <= 1'b1;
  end
`else
  assign wr_block = 1'b0;
  assign wr_err   = 1'b0;
`endif

  // Arbiter FSM: ownership follows this cycle's grant, burst counter tracks
  // consecutive grants to the same owner and clears when the port goes idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= OWNER_B;
    end else if (gnt_a) begin
      state      <= OWN_A;
      last_owner <= OWNER_A;
      burst_cnt  <= (state == OWN_A) ? burst_next : CNT_W'(1);
    end else if (gnt_b) begin
      state      <= OWN_B;
      last_owner <= OWNER_B;
      burst_cnt  <= (state == OWN_B) ? burst_next : CNT_W'(1);
    end else begin
      state      <= IDLE;
      burst_cnt  <= '0;
    end
  end

  // Read return path for A: capture memory data at the grant edge and flag
  // it valid for the following cycle only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rdata_a  <= 16'd0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      if (gnt_a && !we_a) rdata_a <= mem_out;
    end
  end

  // Read return path for B, mirroring A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_b <= 1'b0;
      rdata_b  <= 16'd0;
    end else begin
      rvalid_b <= gnt_b & ~we_b;
      if (gnt_b && !we_b) rdata_b <= mem_out;
    end
  end

  assign state_dbg     = state;
  assign burst_cnt_dbg = burst_cnt;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter with a behavioural Hack data
//   memory attached to the shared port. Read data is checked against a
//   reference image kept by the drivers; grant order is logged and compared
//   against hand-derived round-robin / burst sequences.

module tb_memory_arbiter;

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  localparam int TIMEOUT = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [14:0] addr_a = '0;
  logic [15:0] wdata_a = '0;
  logic        gnt_a, rvalid_a;
  logic [15:0] rdata_a;
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [14:0] addr_b = '0;
  logic [15:0] wdata_b = '0;
  logic        gnt_b, rvalid_b;
  logic [15:0] rdata_b;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_out;
  logic        wr_err;
  logic [1:0]  state_dbg;
  logic [2:0]  burst_cnt_dbg;

  memory_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_in(mem_in), .mem_load(mem_load), .mem_address(mem_address),
    .mem_out(mem_out), .wr_err(wr_err),
    .state_dbg(state_dbg), .burst_cnt_dbg(burst_cnt_dbg)
  );

  // ---------------- memory model ----------------
  function automatic logic [15:0] init_pattern(input logic [14:0] a);
    if (a == 15'h0010) return 16'h1234;
    return {1'b0, a} ^ 16'hA5C3;
  endfunction

  logic [15:0] mem [0:32767];
  assign mem_out = mem[mem_address];
  always @(posedge clk) if (mem_load) mem[mem_address] <= mem_in;

  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_read(input logic [14:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pattern(a);
  endfunction

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic        gnt_log[$];   // 0 = A granted, 1 = B granted

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read data returned by the DUT is matched against the queued expectation.
  always @(negedge clk) begin
    if (rvalid_a) begin
      if (exp_a_q.size() > 0) check("rdata_a", rdata_a, exp_a_q.pop_front());
      else                    check("rvalid_a_unexpected", rvalid_a, 0);
    end
    if (rvalid_b) begin
      if (exp_b_q.size() > 0) check("rdata_b", rdata_b, exp_b_q.pop_front());
      else                    check("rvalid_b_unexpected", rvalid_b, 0);
    end
  end

  // Per-cycle grant invariants and grant-order log.
  always begin
    @(negedge clk);
    #2;
    check("dual_gnt", gnt_a & gnt_b, 0);
    check("load_without_gnt", mem_load & ~(gnt_a | gnt_b), 0);
    if (gnt_a) gnt_log.push_back(1'b0);
    if (gnt_b) gnt_log.push_back(1'b1);
  end

  // ---------------- drivers ----------------
  // Entered just after a falling edge; returns just after the falling edge
  // that follows the grant edge, with the request dropped.
  task automatic access_a(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                          output int waited);
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    waited = 0;
    #1;
    while (!gnt_a && waited < TIMEOUT) begin
      @(negedge clk); #1; waited++;
    end
    if (!gnt_a) check("gnt_a_timeout", gnt_a, 1);
    else if (!we) exp_a_q.push_back(ref_read(addr));
    else if (!(PROT && addr >= 15'h6000)) ref_mem[int'(addr)] = wd;
    @(negedge clk);
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
  endtask

  task automatic access_b(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                          output int waited);
    req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    waited = 0;
    #1;
    while (!gnt_b && waited < TIMEOUT) begin
      @(negedge clk); #1; waited++;
    end
    if (!gnt_b) check("gnt_b_timeout", gnt_b, 1);
    else if (!we) exp_b_q.push_back(ref_read(addr));
    else if (!(PROT && addr >= 15'h6000)) ref_mem[int'(addr)] = wd;
    @(negedge clk);
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int w, wa, wb;
    logic [17:0] burst_pat;

    for (int i = 0; i < 32768; i++) mem[i] = init_pattern(15'(i));

    @(negedge clk);
    apply_reset();

    // Reset state
    check("rst_state", state_dbg, 0);
    check("rst_burst_cnt", burst_cnt_dbg, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    check("rst_wr_err", wr_err, 0);

    // 1: single A read, zero-wait grant, one-cycle read latency
    access_a(1'b0, 15'h0010, 16'h0, w);
    check("t1_gnt_wait", w, 0);
    check("t1_rvalid_a", rvalid_a, 1);
    check("t1_rdata_a", rdata_a, 16'h1234);
    @(negedge clk);
    check("t1_rvalid_a_pulse", rvalid_a, 0);
    check("t1_rdata_a_hold", rdata_a, 16'h1234);
    check("t1_state_idle", state_dbg, 0);

    // 2: tie from IDLE right after reset -> A then B
    apply_reset();
    gnt_log.delete();
    fork
      access_a(1'b0, 15'h0020, 16'h0, wa);
      access_b(1'b0, 15'h0030, 16'h0, wb);
    join
    check("t2_log_len", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t2_first_A", gnt_log[0], 0);
      check("t2_second_B", gnt_log[1], 1);
    end
    check("t2_wait_a", wa, 0);
    check("t2_wait_b", wb, 1);

    // 3: B streams 10 reads, A joins one cycle later with 8 reads
    @(negedge clk);
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) access_b(1'b0, 15'(16'h0100 + i), 16'h0, wb);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 8; i++) access_a(1'b0, 15'(16'h0200 + i), 16'h0, wa);
      end
    join
    burst_pat = 18'b111100001111000011;
    check("t3_log_len", gnt_log.size(), 18);
    if (gnt_log.size() == 18) begin
      for (int i = 0; i < 18; i++) check($sformatf("t3_order_%0d", i), gnt_log[i], burst_pat[17-i]);
    end

    // 4: B write then A read of same word
    @(negedge clk);
    access_b(1'b1, 15'h4000, 16'hBEEF, w);
    access_a(1'b0, 15'h4000, 16'h0, w);
    check("t4_rdata_a", rdata_a, 16'hBEEF);
    @(negedge clk);

    // 5: write into the protected window
    check("t5_wr_err_before", wr_err, 0);
    req_a = 1'b1; we_a = 1'b1; addr_a = 15'h6000; wdata_a = 16'h00FF;
    #1;
    check("t5_gnt_a", gnt_a, 1);
    check("t5_mem_load", mem_load, PROT ? 0 : 1);
    check("t5_mem_address", mem_address, 15'h6000);
    check("t5_mem_in", mem_in, 16'h00FF);
    @(negedge clk);
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    if (!PROT) ref_mem[int'(15'h6000)] = 16'h00FF;
    check("t5_wr_err", wr_err, PROT ? 1 : 0);
    access_a(1'b0, 15'h6000, 16'h0, w);
    check("t5_wr_err_sticky", wr_err, PROT ? 1 : 0);

    // 6: reset asserted in a B read grant cycle, mid-burst
    @(negedge clk);
    access_b(1'b0, 15'h0120, 16'h0, w);
    req_b = 1'b1; we_b = 1'b0; addr_b = 15'h0123;
    rst_n = 1'b0;
    #1;
    check("t6_gnt_b_in_reset", gnt_b, 0);
    check("t6_gnt_a_in_reset", gnt_a, 0);
    check("t6_mem_load_in_reset", mem_load, 0);
    @(negedge clk);
    check("t6_rvalid_b", rvalid_b, 0);
    check("t6_rdata_b", rdata_b, 0);
    check("t6_state", state_dbg, 0);
    check("t6_burst_cnt", burst_cnt_dbg, 0);
    check("t6_wr_err_cleared", wr_err, 0);
    req_b = 1'b0; addr_b = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rvalid_b_after", rvalid_b, 0);

    // Tie again after reset: A must win first
    gnt_log.delete();
    fork
      access_a(1'b0, 15'h0300, 16'h0, wa);
      access_b(1'b0, 15'h0301, 16'h0, wb);
    join
    check("t6_tie_len", gnt_log.size(), 2);
    if (gnt_log.size() == 2) check("t6_tie_first_A", gnt_log[0], 0);

    // Random mixed traffic from both sides
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          access_a(1'($urandom_range(0, 1)), 15'($urandom_range(16'h0400, 16'h0410)),
                   16'($urandom_range(0, 16'hFFFF)), wa);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          access_b(1'($urandom_range(0, 1)), 15'($urandom_range(16'h0408, 16'h0418)),
                   16'($urandom_range(0, 16'hFFFF)), wb);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    repeat (3) @(negedge clk);
    check("exp_a_q_drained", exp_a_q.size(), 0);
    check("exp_b_q_drained", exp_b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
